seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits, each showing a 4-bit hex value. It sits between parking-lot counters and logic (free-space count, gate codes) and the board display. It adds four things: a scan counter, tear-free double-buffered loads at frame boundaries, leading-zero blanking, and optional per-digit blinking.

## Interface
Parameters:
- DIGITS, 4, number of digits scanned (1–8)
- SCAN_DIV, 50000, clock cycles each digit is driven per frame (≥2)
- BLINK_FRAMES, 64, frames per blink half-period (≥1; used only with blink compiled in)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- load  in  1  single-cycle strobe; captures value into shadow register
- value  in  4*DIGITS  nibble i = digit i; digit 0 is least significant (rightmost)
- blank_lz  in  1  1 = blank leading zero digits
- blink_mask  in  DIGITS  1 = digit i blinks
- seg  out  7  active-low segments; seg[0]=a … seg[6]=g
- digit_sel  out  DIGITS  active-low digit enable, one-hot-low
- frame_done  out  1  one-cycle pulse on the frame wrap cycle

## Operation
Storage:
- shadow[4*DIGITS], active[4*DIGITS] and pending.
- load: shadow<=value, pending<=1.
- On the frame wrap cycle, if pending is 1: active<=shadow, then pending<=load. A load on the wrap cycle therefore transfers at the next wrap, with its own data.

Scan:
- div counts 0..SCAN_DIV-1. At SCAN_DIV-1, div wraps to 0 and idx advances.
- idx wraps DIGITS-1 -> 0; that cycle is the frame wrap cycle.

Decode of nibble active[idx], registered:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Bit order is g..a.

Blanking (seg forced to 1111111):
- Leading zero: applies when blank_lz=1, digit idx>0, and every nibble from idx up to DIGITS-1 is 0. Digit 0 is never blanked, so value 0 shows "0".
- Blink: applies when blink compiled in, blink_mask[idx]=1 and phase=1.

Outputs:
- digit_sel: bit idx low, all other bits high.
- frame_done: high for one cycle on each wrap.

Reset (asynchronous, mid-frame included):
- div=0, idx=0, shadow=0, active=0, pending=0, phase=0.
- seg=1111111, digit_sel all 1, frame_done=0.
- The first digit is driven on the first clock edge after reset release.

## Timing
- seg and digit_sel are registered together, 1 cycle after idx changes. They never disagree on any cycle.
- Frame length is DIGITS*SCAN_DIV cycles.
- Load-to-visible latency: up to one frame plus 1 cycle.
- Multiple loads within one frame: the last one wins.
- blank_lz and blink_mask are sampled every cycle, with no buffering.

## Configuration
- SEG_SCAN_BLINK_EN defined: a frame counter toggles phase every BLINK_FRAMES frame wraps, and masked digits are blanked while phase=1.
- SEG_SCAN_BLINK_EN undefined: no frame counter or phase register is built, and the blink_mask port exists but is ignored.

## Test plan
Bench configuration: DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- Reset release: digit_sel=1110 and seg=1000000 after the first edge, then digit_sel steps 1101, 1011, 0111 every 4 cycles; frame_done pulses every 16 cycles.
- Load 16'h12AF mid-frame: the old value stays until the wrap; the next frame shows digits 0..3 = 0001110, 0001000, 0100100, 1111001.
- blank_lz=1, load 16'h0050: digits 3 and 2 read 1111111, digit 1 reads 0010010, digit 0 reads 1000000. Load 16'h0000: only digit 0 lit.
- Load asserted exactly on the wrap cycle with 16'h3333, previous shadow 16'h1111: 1111 shows this frame, 3333 shows next frame.
- Blink (macro on), blink_mask=0001: digit 0 is blank for frames 2–3 and lit for frames 0–1 and 4–5. With the macro off, digit 0 is always lit.
- Assert reset mid-frame at idx=2: outputs go to 1111111 / 1111 immediately without waiting for a clock edge, and active and shadow clear to 0.

Source files
------------

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous double buffering.
// Optional per-digit blinking is compiled in when SEG_SCAN_BLINK_EN is defined.
`timescale 1ns/1ps

module seg_scan_display #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]    SEG_OFF  = 7'b1111111;

    logic [DW-1:0]         div;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   shadow;
    logic [4*DIGITS-1:0]   active;
    logic                  pending;
    logic                  phase;
    logic                  div_wrap;
    logic                  frame_wrap;

    logic [3:0]            nib;
    logic [DIGITS-1:0]     sel_next;
    logic                  all_zero;
    logic                  lz_blank;
    logic                  mask_hit;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign div_wrap   = (div == DIV_LAST);
    assign frame_wrap = div_wrap && (idx == IDX_LAST);
    assign frame_done = frame_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
            idx <= '0;
        end else begin
            div <= div_wrap ? '0 : div + 1'b1;
            if (div_wrap)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // NOTE: shadow/active are a handful of flops, not a RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (load)
                shadow <= value;
            // A load coinciding with the transfer re-arms pending for the next wrap.
            if (frame_wrap && pending) begin
                active  <= shadow;
                pending <= load;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BF_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_wrap) begin
            if (frame_cnt == BF_LAST) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    assign phase = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        nib      = 4'h0;
        sel_next = '1;
        all_zero = 1'b1;
        lz_blank = 1'b0;
        mask_hit = 1'b0;
        // Walk from the most significant digit down, tracking "all zero from here up".
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (active[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                nib         = active[4*i +: 4];
                lz_blank    = blank_lz && (i != 0) && all_zero;
                mask_hit    = blink_mask[i];
                sel_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg       <= SEG_OFF;
            digit_sel <= '1;
        end else begin
            seg       <= (lz_blank || (phase && mask_hit)) ? SEG_OFF : seg_decode(nib);
            digit_sel <= sel_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Frame-level bench for seg_scan_display (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2).
// Per-frame vectors push expected digit slots to a queue; a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_seg_scan_display;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int FRAME_LEN = DIGITS * SCAN_DIV;

`ifdef SEG_SCAN_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SB = 7'b1111111;

    typedef struct {
        logic [15:0] v1;
        int          at1;
        logic [15:0] v2;
        int          at2;
        logic        blz;
        logic [3:0]  mask;
        logic [27:0] exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              load;
    logic [15:0]       value;
    logic              blank_lz;
    logic [3:0]        blink_mask;
    logic [6:0]        seg;
    logic [3:0]        digit_sel;
    logic              frame_done;

    int                checks = 0;
    int                errors = 0;
    int                edges  = 0;
    int                base   = 0;
    int                n;
    bit                mon_en = 1'b0;
    logic [10:0]       sb[$];
    logic [10:0]       cur = '0;
    vec_t              vecs[13];

    seg_scan_display #(
        .DIGITS(DIGITS),
        .SCAN_DIV(SCAN_DIV),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load(load),
        .value(value),
        .blank_lz(blank_lz),
        .blink_mask(blink_mask),
        .seg(seg),
        .digit_sel(digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] mk(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Monitor: n = rising edges since reset release; each digit slot lasts SCAN_DIV cycles.
    always @(negedge clk) begin
        if (mon_en) begin
            n = edges - base;
            if (n > 0) begin
                check("frame_done", {31'b0, frame_done}, {31'b0, (n % FRAME_LEN) == FRAME_LEN - 1});
                if ((n - 1) % SCAN_DIV == 0) begin
                    check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0)
                        cur = sb.pop_front();
                end
                check("digit_sel", {28'b0, digit_sel}, {28'b0, cur[10:7]});
                check("seg", {25'b0, seg}, {25'b0, cur[6:0]});
            end
        end
    end

    task automatic run_frame(input vec_t v);
        #1;
        blank_lz   = v.blz;
        blink_mask = v.mask;
        for (int d = 0; d < DIGITS; d++)
            sb.push_back({~(4'b0001 << d), v.exp[7*d +: 7]});
        for (int j = 1; j <= FRAME_LEN; j++) begin
            load = (j == v.at1) || (j == v.at2);
            if (j == v.at1) value = v.v1;
            if (j == v.at2) value = v.v2;
            @(posedge clk);
            #1;
        end
        load = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset  = 1'b0;
        base   = edges;
        mon_en = 1'b1;
    endtask

    // Leave a pending load of 7777 in flight, then reset asynchronously while idx=2.
    task automatic mid_frame_reset();
        mon_en = 1'b0;
        check("sb_drained", sb.size(), 32'd0);
        load  = 1'b1;
        value = 16'h7777;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_sel", {28'b0, digit_sel}, 32'b1011);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_seg", {25'b0, seg}, {25'b0, SB});
        check("rst_async_sel", {28'b0, digit_sel}, 32'hF);
        check("rst_async_fd", {31'b0, frame_done}, 32'd0);
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{16'h12AF,  6, 16'h0000,  0, 1'b0, 4'h0, mk(S0, S0, S0, S0)};
        vecs[1]  = '{16'h9999,  3, 16'h0050, 10, 1'b1, 4'h0, mk(S1, S2, SA, SF)};
        vecs[2]  = '{16'h0000,  5, 16'h0000,  0, 1'b1, 4'h0, mk(SB, SB, S5, S0)};
        vecs[3]  = '{16'h1111,  8, 16'h3333, 16, 1'b1, 4'h0, mk(SB, SB, SB, S0)};
        vecs[4]  = '{16'h0000,  0, 16'h0000,  0, 1'b1, 4'h0, mk(S1, S1, S1, S1)};
        vecs[5]  = '{16'h0000,  0, 16'h0000,  0, 1'b1, 4'h0, mk(S3, S3, S3, S3)};
        vecs[6]  = '{16'h0000,  0, 16'h0000,  0, 1'b0, 4'h0, mk(S3, S3, S3, S3)};
        vecs[7]  = '{16'h0000,  0, 16'h0000,  0, 1'b0, 4'h1, mk(S0, S0, S0, S0)};
        vecs[8]  = '{16'h0000,  0, 16'h0000,  0, 1'b0, 4'h1, mk(S0, S0, S0, S0)};
        vecs[9]  = '{16'h0000,  0, 16'h0000,  0, 1'b0, 4'h1, mk(S0, S0, S0, BLINK_ON ? SB : S0)};
        vecs[10] = '{16'h0000,  0, 16'h0000,  0, 1'b0, 4'h1, mk(S0, S0, S0, BLINK_ON ? SB : S0)};
        vecs[11] = '{16'h0000,  0, 16'h0000,  0, 1'b0, 4'h1, mk(S0, S0, S0, S0)};
        vecs[12] = '{16'h0000,  0, 16'h0000,  0, 1'b0, 4'h1, mk(S0, S0, S0, S0)};

        reset      = 1'b1;
        load       = 1'b0;
        value      = 16'h0000;
        blank_lz   = 1'b0;
        blink_mask = 4'h0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_seg", {25'b0, seg}, {25'b0, SB});
        check("rst_sel", {28'b0, digit_sel}, 32'hF);
        check("rst_fd", {31'b0, frame_done}, 32'd0);
        release_reset();

        for (int i = 0; i < 13; i++) begin
            if (i == 7)
                mid_frame_reset();
            run_frame(vecs[i]);
        end

        check("sb_final", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
